// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the pipelined RV32 core.
// Owns the program counter, keeps at most one request outstanding to
// instruction memory, and presents either the fetched word or a 32'd0
// bubble to the IF/ID register.
// Optional feature macro: FETCH_MISALIGN_CHK_EN (aligns misaligned redirect
// targets and raises a sticky misalign_err flag).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        FetchWait,
  output logic        misalign_err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    DROP = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] redirect_pc;

`ifdef FETCH_MISALIGN_CHK_EN
  logic err_q, err_d;

  // Misaligned redirect targets are forced onto a word boundary.
  assign redirect_pc = {PCTargetE[31:2], 2'b00};

  // Sticky error: once a misaligned redirect is seen it stays until reset.
  always_comb begin
    err_d = err_q;
    if (PCSrcE && (PCTargetE[1:0] != 2'b00)) begin
      err_d = 1'b1;
    end
  end

  // Error flag register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign misalign_err = err_q;
`else
  // Target taken verbatim; no misalignment tracking.
  assign redirect_pc  = PCTargetE;
  assign misalign_err = 1'b0;
`endif

  // State, PC and held-instruction registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  // Next-state logic; a redirect overrides both normal sequencing and StallF.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    if (PCSrcE) begin
      pc_d = redirect_pc;
      unique case (state_q)
        IDLE:    state_d = REQ;
        // An accepted old request still owes us a response: drain it.
        REQ:     state_d = imem_gnt ? DROP : REQ;
        // Response arriving with the redirect is simply discarded.
        WAIT:    state_d = imem_rvalid ? REQ : DROP;
        HOLD:    state_d = REQ;
        DROP:    state_d = imem_rvalid ? REQ : DROP;
        default: state_d = IDLE;
      endcase
    end else begin
      unique case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (imem_gnt) begin
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            state_d = HOLD;
            inst_d  = imem_rdata;
          end
        end
        HOLD: begin
          if (!StallF) begin
            pc_d    = pc_q + 32'd4;
            state_d = REQ;
          end
        end
        DROP: begin
          if (imem_rvalid) begin
            state_d = REQ;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs decode registered state only; no input-to-output paths.
  assign imem_req    = (state_q == REQ);
  assign imem_addr   = pc_q;
  assign PCF         = pc_q;
  assign PCPlus4F    = pc_q + 32'd4;
  assign instruction = (state_q == HOLD) ? inst_q : 32'd0;
  assign FetchWait   = (state_q != HOLD);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized self-checking bench for fetch_unit.
// The reference model tracks "instruction ready", "request outstanding" and
// "outstanding response is stale" flags rather than a state machine.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        FetchWait;
  logic        misalign_err;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk          (clk),
    .rst          (rst),
    .StallF       (StallF),
    .PCSrcE       (PCSrcE),
    .PCTargetE    (PCTargetE),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instruction  (instruction),
    .PCF          (PCF),
    .PCPlus4F     (PCPlus4F),
    .FetchWait    (FetchWait),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state.
  bit          m_started;
  bit          m_have;
  bit          m_out;
  bit          m_stale;
  bit          m_err;
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_oaddr;

  // Stimulus knobs (percentages).
  int          gnt_pct, rv_pct, stall_pct, redir_pct;
  bit          fix_tgt_en, allow_mis, dir_data;
  logic [31:0] fix_tgt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_target(input logic [31:0] t);
`ifdef FETCH_MISALIGN_CHK_EN
    return {t[31:2], 2'b00};
`else
    return t;
`endif
  endfunction

  function automatic bit exp_err_hit(input logic [31:0] t);
`ifdef FETCH_MISALIGN_CHK_EN
    return t[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_started = 0; m_have = 0; m_out = 0; m_stale = 0; m_err = 0;
    m_pc = RPC; m_inst = 32'd0; m_oaddr = RPC;
  endtask

  task automatic check_outputs();
    logic req;
    req = m_started && !m_have && !m_out;
    check_eq("imem_req",    {31'd0, imem_req}, {31'd0, req});
    check_eq("pcf",         PCF, m_pc);
    check_eq("imem_addr",   imem_addr, m_pc);
    check_eq("pcplus4",     PCPlus4F, m_pc + 32'd4);
    check_eq("instruction", instruction, m_have ? m_inst : 32'd0);
    check_eq("fetchwait",   {31'd0, FetchWait}, {31'd0, !m_have});
    check_eq("misalign",    {31'd0, misalign_err}, {31'd0, m_err});
  endtask

  // Apply the model's view of one clock edge given the inputs now driven.
  task automatic model_step();
    bit req, acc, dat;
    req = m_started && !m_have && !m_out;
    acc = req && imem_gnt;
    dat = imem_rvalid && m_out;
    if (PCSrcE && exp_err_hit(PCTargetE)) m_err = 1;
    if (!m_started) begin
      m_started = 1;
      if (PCSrcE) m_pc = exp_target(PCTargetE);
    end else if (PCSrcE) begin
      m_pc   = exp_target(PCTargetE);
      m_have = 0;
      if (acc) begin
        m_out = 1; m_stale = 1;
      end else if (m_out) begin
        if (dat) m_out = 0;
        else     m_stale = 1;
      end
    end else if (acc) begin
      m_out = 1; m_stale = 0; m_oaddr = m_pc;
    end else if (dat) begin
      m_out = 0;
      if (!m_stale) begin
        m_have = 1; m_inst = imem_rdata;
        $display("fetch pc=%h inst=%h", m_pc, imem_rdata);
      end
      m_stale = 0;
    end else if (m_have && !StallF) begin
      m_pc   = m_pc + 32'd4;
      m_have = 0;
    end
  endtask

  // One cycle: check at the negedge, drive inputs, advance model, next negedge.
  task automatic cycle();
    logic [31:0] t;
    check_outputs();
    imem_gnt    = ($urandom_range(99) < gnt_pct);
    imem_rvalid = m_out && ($urandom_range(99) < rv_pct);
    imem_rdata  = dir_data ? {16'hD00D, m_oaddr[15:0]} : $urandom;
    StallF      = ($urandom_range(99) < stall_pct);
    PCSrcE      = ($urandom_range(99) < redir_pct);
    if (fix_tgt_en) begin
      t = fix_tgt;
    end else begin
      t = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      if (!allow_mis || $urandom_range(9) != 0) t[1:0] = 2'b00;
    end
    PCTargetE = t;
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    model_reset();
    check_outputs();
    check_eq("rst_pcf", PCF, RPC);
    check_eq("rst_inst", instruction, 32'd0);
    check_eq("rst_err", {31'd0, misalign_err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1; StallF = 0; PCSrcE = 0; PCTargetE = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    gnt_pct = 100; rv_pct = 100; stall_pct = 0; redir_pct = 0;
    fix_tgt_en = 0; fix_tgt = 0; allow_mis = 0; dir_data = 1;
    @(negedge clk);
    do_reset();

    // Zero-wait memory: first word 3 cycles after release, next 3 later.
    repeat (3) cycle();
    check_eq("first_inst", instruction, 32'hD00D_0100);
    repeat (3) cycle();
    check_eq("second_inst", instruction, 32'hD00D_0104);
    check_eq("second_pcf", PCF, 32'h104);

    // Stall in HOLD for 4 cycles: instruction and PC held, no request.
    stall_pct = 100;
    repeat (4) begin
      check_eq("stall_inst", instruction, 32'hD00D_0104);
      check_eq("stall_pcf", PCF, 32'h104);
      check_eq("stall_req", {31'd0, imem_req}, 32'd0);
      cycle();
    end
    stall_pct = 0;
    cycle();
    check_eq("unstall_pcf", PCF, 32'h108);

    // Reach HOLD, then misaligned redirect while stalled: redirect wins.
    repeat (2) cycle();
    check_eq("hold_again", {31'd0, FetchWait}, 32'd0);
    stall_pct = 100; redir_pct = 100; fix_tgt_en = 1; fix_tgt = 32'h202;
    cycle();
    stall_pct = 0; redir_pct = 0; fix_tgt_en = 0;
    check_eq("redir_pcf", PCF, exp_target(32'h202));
    check_eq("redir_inst", instruction, 32'd0);
    check_eq("redir_err", {31'd0, misalign_err}, {31'd0, exp_err_hit(32'h202)});
    repeat (5) cycle();
    check_eq("err_sticky", {31'd0, misalign_err}, {31'd0, exp_err_hit(32'h202)});
    @(negedge clk);
    do_reset();

    // Randomized phase: variable latency, stalls, redirects, wrap targets.
    dir_data = 0; allow_mis = 1;
    gnt_pct = 60; rv_pct = 50; stall_pct = 40; redir_pct = 12;
    repeat (1500) cycle();
    gnt_pct = 100; rv_pct = 100; redir_pct = 30;
    repeat (400) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
